// File: rtl/ddr4_dq_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_dq_sched_pkg
// Brief    : Shared types and sizing helpers for the DQ direction scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package ddr4_dq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } dir_e;

    localparam int BURST_BL8 = 4;
    localparam int BURST_BC4 = 2;

    // Deep enough for the longest window plus its trailing guard band.
    function automatic int sched_depth(input int cl, input int cwl, input int post, input int turn);
        return ((cl > cwl) ? cl : cwl) + BURST_BL8 + post + turn + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr4_dq_timeline.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_dq_timeline
// Brief    : Direction slot shift register with ranged conflict check/insert.
// Revision : 1.0 - initial release
// ============================================================================
module ddr4_dq_timeline
    import ddr4_dq_sched_pkg::*;
#(
    parameter int DEPTH    = 24,
    parameter int MIN_TURN = 2,
    parameter int IDX_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  dir_e             i_dir,
    input  logic [IDX_W-1:0] i_start,
    input  logic [IDX_W-1:0] i_end,
    input  logic             i_insert,
    output logic             o_conflict,
    output dir_e             o_slot0
);

    dir_e r_slot  [DEPTH];
    dir_e w_shift [DEPTH];

    // Checks and inserts are made against the already-advanced timeline.
    for (genvar g = 0; g < DEPTH; g++) begin : g_shift
        if (g == DEPTH - 1) begin : g_tail
            assign w_shift[g] = IDLE;
        end else begin : g_body
            assign w_shift[g] = r_slot[g+1];
        end
    end

    always_comb begin
        o_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((i + MIN_TURN >= int'(i_start)) && (i <= int'(i_end) + MIN_TURN) &&
                (w_shift[i] != IDLE) && (w_shift[i] != i_dir)) begin
                o_conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                r_slot[i] <= IDLE;
            end else if (i_insert && (i >= int'(i_start)) && (i <= int'(i_end))) begin
                r_slot[i] <= i_dir;
            end else begin
                r_slot[i] <= w_shift[i];
            end
        end
    end

    assign o_slot0 = r_slot[0];

endmodule
`default_nettype wire

// File: rtl/ddr4_dq_dir_sched.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_dq_dir_sched
// Brief    : DQ/DQS bus-direction scheduler with turnaround enforcement.
// Revision : 1.0 - initial release
// ============================================================================
module ddr4_dq_dir_sched
    import ddr4_dq_sched_pkg::*;
#(
    parameter int CWL      = 12,
    parameter int CL       = 16,
    parameter int PRE_WR   = 1,
    parameter int PRE_RD   = 1,
    parameter int POST     = 1,
    parameter int MIN_TURN = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_wr,
    input  logic             cmd_rd,
    input  logic             cmd_bc4,
    output logic             wr_drive,
    output logic             rd_drive,
    output logic [1:0]       dir_state,
    output logic             err_conflict,
    output logic             err_illegal,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] rej_cnt
);

    localparam int c_depth = sched_depth(CL, CWL, POST, MIN_TURN);
    localparam int c_idx_w = $clog2(c_depth);

    // Slot k holds the cycle k+1 after the command, hence the -1 / -2 offsets.
    localparam logic [c_idx_w-1:0] c_wr_start   = c_idx_w'(CWL - PRE_WR - 1);
    localparam logic [c_idx_w-1:0] c_wr_end_bl8 = c_idx_w'(CWL + BURST_BL8 + POST - 2);
    localparam logic [c_idx_w-1:0] c_wr_end_bc4 = c_idx_w'(CWL + BURST_BC4 + POST - 2);
    localparam logic [c_idx_w-1:0] c_rd_start   = c_idx_w'(CL - PRE_RD - 1);
    localparam logic [c_idx_w-1:0] c_rd_end_bl8 = c_idx_w'(CL + BURST_BL8 + POST - 2);
    localparam logic [c_idx_w-1:0] c_rd_end_bc4 = c_idx_w'(CL + BURST_BC4 + POST - 2);
    localparam logic [CNT_W-1:0]   c_cnt_one    = CNT_W'(1);

    if (CWL <= PRE_WR) begin : g_chk_cwl
        $error("ddr4_dq_dir_sched: CWL must exceed PRE_WR");
    end
    if (CL <= PRE_RD) begin : g_chk_cl
        $error("ddr4_dq_dir_sched: CL must exceed PRE_RD");
    end

    logic               w_illegal;
    logic               w_single;
    logic               w_conflict;
    logic               w_accept;
    logic               w_reject;
    dir_e               w_dir;
    dir_e               w_slot0;
    logic [c_idx_w-1:0] w_start;
    logic [c_idx_w-1:0] w_end;

    logic               r_err_conflict;
    logic               r_err_illegal;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [CNT_W-1:0]   r_rej_cnt;

    always_comb begin
        w_illegal = cmd_wr & cmd_rd;
        w_single  = cmd_wr ^ cmd_rd;
        w_dir     = cmd_wr ? WR : RD;
        if (cmd_wr) begin
            w_start = c_wr_start;
            w_end   = cmd_bc4 ? c_wr_end_bc4 : c_wr_end_bl8;
        end else begin
            w_start = c_rd_start;
            w_end   = cmd_bc4 ? c_rd_end_bc4 : c_rd_end_bl8;
        end
        w_accept = w_single & ~w_conflict;
        w_reject = w_single & w_conflict;
    end

    ddr4_dq_timeline #(
        .DEPTH    (c_depth),
        .MIN_TURN (MIN_TURN),
        .IDX_W    (c_idx_w)
    ) u_timeline (
        .clk        (clk),
        .rst        (rst),
        .i_dir      (w_dir),
        .i_start    (w_start),
        .i_end      (w_end),
        .i_insert   (w_accept),
        .o_conflict (w_conflict),
        .o_slot0    (w_slot0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_conflict <= 1'b0;
            r_err_illegal  <= 1'b0;
            r_wr_cnt       <= '0;
            r_rd_cnt       <= '0;
            r_rej_cnt      <= '0;
        end else begin
            r_err_conflict <= w_reject;
            r_err_illegal  <= w_illegal;
            if (w_accept && cmd_wr && (r_wr_cnt != '1)) begin
                r_wr_cnt <= r_wr_cnt + c_cnt_one;
            end
            if (w_accept && cmd_rd && (r_rd_cnt != '1)) begin
                r_rd_cnt <= r_rd_cnt + c_cnt_one;
            end
            if ((w_reject || w_illegal) && (r_rej_cnt != '1)) begin
                r_rej_cnt <= r_rej_cnt + c_cnt_one;
            end
        end
    end

    assign wr_drive     = (w_slot0 == WR);
    assign rd_drive     = (w_slot0 == RD);
    assign dir_state    = w_slot0;
    assign err_conflict = r_err_conflict;
    assign err_illegal  = r_err_illegal;
    assign wr_cnt       = r_wr_cnt;
    assign rd_cnt       = r_rd_cnt;
    assign rej_cnt      = r_rej_cnt;

    a_drive_exclusive: assert property (@(posedge clk) disable iff (rst) !(wr_drive && rd_drive));

endmodule
`default_nettype wire
